// File: rtl/rename_pkg.sv
// Shared constants, FSM state type and free-list index helper for the
// rename-stage free-list recovery sequencer.
package rename_pkg;

  localparam int NUM_FL = 48;
  localparam int PREG_W = 7;
  localparam int IDX_W  = 6;
  localparam int LANES  = 8;
  localparam int BEAT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SNAP,
    ST_COPY,
    ST_LOAD
  } rec_state_e;

  // Base is below NUM_FL and inc is below NUM_FL, so one conditional subtract wraps.
  function automatic logic [IDX_W-1:0] fl_wrap_add(input logic [IDX_W-1:0] base,
                                                    input logic [IDX_W:0]   inc);
    logic [IDX_W:0] sum;
    sum = {1'b0, base} + inc;
    if (sum >= (IDX_W+1)'(NUM_FL)) sum = sum - (IDX_W+1)'(NUM_FL);
    return sum[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/rfl_dup_chk.sv
// Duplicate-tag checker: flags any copied tag seen earlier in the run or
// repeated within the same beat. Error is sticky until reset.
module rfl_dup_chk
  import rename_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clr_i,
  input  logic [LANES-1:0]        act_i,
  input  logic [LANES*PREG_W-1:0] tag_i,
  output logic                    err_o
);

  logic [2**PREG_W-1:0] seen_q, seen_d;
  logic                 err_q, err_d;

  // Lanes are folded in order, so a lower lane's tag is already marked when a
  // higher lane of the same beat is tested.
  always_comb begin
    logic [PREG_W-1:0] tag;
    tag    = '0;
    seen_d = clr_i ? '0 : seen_q;
    err_d  = err_q;
    for (int k = 0; k < LANES; k++) begin
      tag = tag_i[k*PREG_W +: PREG_W];
      if (act_i[k]) begin
        if (seen_d[tag]) err_d = 1'b1;
        seen_d[tag] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seen_q <= '0;
      err_q  <= 1'b0;
    end else begin
      seen_q <= seen_d;
      err_q  <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/rfl_recover_seq.sv
// Rebuilds the speculative free list from the architectural one after a
// mispredict, LANES entries per beat. Define RFL_REC_CHECK_EN for the duplicate-tag checker.
module rfl_recover_seq
  import rename_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    recover_req_i,
  input  logic [IDX_W-1:0]        arch_fl_head_i,
  input  logic [IDX_W-1:0]        arch_fl_cnt_i,
  output logic [LANES*IDX_W-1:0]  arch_rd_idx_o,
  input  logic [LANES*PREG_W-1:0] arch_rd_data_i,
  output logic [LANES-1:0]        spec_wr_we_o,
  output logic [LANES*IDX_W-1:0]  spec_wr_idx_o,
  output logic [LANES*PREG_W-1:0] spec_wr_data_o,
  output logic                    spec_ptr_load_o,
  output logic [IDX_W-1:0]        spec_head_o,
  output logic [IDX_W-1:0]        spec_tail_o,
  output logic [IDX_W-1:0]        spec_cnt_o,
  output logic                    rename_stall_o,
  output logic                    retire_hold_o,
  output logic                    rec_done_o,
  output logic                    rec_err_o
);

  rec_state_e        state_q, state_d;
  logic [IDX_W-1:0]  head_q, head_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [IDX_W-1:0]  cnt_clamped;
  logic [IDX_W:0]    beat_base;
  logic              last_beat;
  logic              load_fire;
  logic [LANES-1:0]  lane_act;

  assign cnt_clamped = (arch_fl_cnt_i > IDX_W'(NUM_FL)) ? IDX_W'(NUM_FL) : arch_fl_cnt_i;
  assign beat_base   = (IDX_W+1)'(beat_q) << $clog2(LANES);
  assign last_beat   = (beat_base + (IDX_W+1)'(LANES)) >= {1'b0, cnt_q};

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    unique case (state_q)
      ST_IDLE: if (recover_req_i) state_d = ST_SNAP;
      ST_SNAP: begin
        head_d  = arch_fl_head_i;
        cnt_d   = cnt_clamped;
        beat_d  = '0;
        state_d = (cnt_clamped != '0) ? ST_COPY : ST_LOAD;
      end
      ST_COPY: begin
        beat_d = beat_q + 1'b1;
        if (last_beat) state_d = ST_LOAD;
      end
      ST_LOAD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A new mispredict overrides whatever run is in flight.
    if (recover_req_i && (state_q != ST_IDLE)) state_d = ST_SNAP;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      head_q  <= '0;
      cnt_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    logic [IDX_W:0] pos;
    pos            = '0;
    lane_act       = '0;
    arch_rd_idx_o  = '0;
    spec_wr_idx_o  = '0;
    spec_wr_data_o = '0;
    for (int k = 0; k < LANES; k++) begin
      pos         = beat_base + (IDX_W+1)'(k);
      lane_act[k] = (state_q == ST_COPY) && (pos < {1'b0, cnt_q});
      if (lane_act[k]) begin
        arch_rd_idx_o[k*IDX_W +: IDX_W]    = fl_wrap_add(head_q, pos);
        spec_wr_idx_o[k*IDX_W +: IDX_W]    = pos[IDX_W-1:0];
        spec_wr_data_o[k*PREG_W +: PREG_W] = arch_rd_data_i[k*PREG_W +: PREG_W];
      end
    end
  end

  assign spec_wr_we_o = lane_act;

  // A request arriving in LOAD aborts the run, so the pointer load is withheld.
  assign load_fire       = (state_q == ST_LOAD) && !recover_req_i;
  assign spec_ptr_load_o = load_fire;
  assign rec_done_o      = load_fire;
  assign spec_head_o     = '0;
  assign spec_tail_o     = (load_fire && (cnt_q != IDX_W'(NUM_FL))) ? cnt_q : '0;
  assign spec_cnt_o      = load_fire ? cnt_q : '0;
  assign rename_stall_o  = (state_q != ST_IDLE);
  assign retire_hold_o   = (state_q != ST_IDLE);

`ifdef RFL_REC_CHECK_EN
  rfl_dup_chk u_dup_chk (
    .clock (clock),
    .reset (reset),
    .clr_i (state_q == ST_SNAP),
    .act_i (lane_act),
    .tag_i (arch_rd_data_i),
    .err_o (rec_err_o)
  );
`else
  assign rec_err_o = 1'b0;
`endif

endmodule

// File: doc/rfl_recover_seq.md
# rfl_recover_seq

Free-list recovery sequencer for the rename stage. On a branch misprediction it rebuilds the speculative free register list from the architectural free list. It copies up to 8 entries per cycle through the spec list's write ports, then loads new head, tail and count values. While it runs, it holds rename and retirement so neither list changes mid-copy.

## Interface
Parameters:
- NUM_FL, 48, entries in each free list
- PREG_W, 7, physical register tag width
- IDX_W, 6, free-list index / count width
- LANES, 8, entries copied per cycle

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- recover_req_i  in  1  misprediction recovery request, sampled every cycle
- arch_fl_head_i  in  IDX_W  architectural list head index
- arch_fl_cnt_i  in  IDX_W  architectural list valid-entry count, 0..48
- arch_rd_idx_o  out  LANES*IDX_W  arch list read indices, lane k in bits [k*IDX_W +: IDX_W]
- arch_rd_data_i  in  LANES*PREG_W  arch list read data, same cycle as index
- spec_wr_we_o  out  LANES  spec list write enables
- spec_wr_idx_o  out  LANES*IDX_W  spec list write indices
- spec_wr_data_o  out  LANES*PREG_W  spec list write data
- spec_ptr_load_o  out  1  one-cycle pulse; spec list loads head, tail and count
- spec_head_o / spec_tail_o / spec_cnt_o  out  IDX_W each  values to load
- rename_stall_o  out  1  rename must not allocate
- retire_hold_o  out  1  retire must not release registers
- rec_done_o  out  1  one-cycle completion pulse
- rec_err_o  out  1  sticky checker error (see Configuration)

## Operation
- FSM states: IDLE, SNAP, COPY, LOAD.
- IDLE → SNAP when recover_req_i is high.
- SNAP lasts one cycle. It latches arch_fl_head_i into snap_head and arch_fl_cnt_i into snap_cnt, clears beat counter b, and asserts retire_hold_o. This cycle absorbs retire releases already in flight.
- SNAP → COPY if snap_cnt ≠ 0; otherwise SNAP → LOAD.
- COPY, beat b: lane k is active when 8b+k < snap_cnt.
  - arch_rd_idx = (snap_head + 8b + k) mod 48; the wrap uses a subtract, not a divider.
  - spec_wr_idx = 8b + k.
  - spec_wr_data = arch_rd_data of lane k.
  - we = active.
- COPY → LOAD after beat ceil(snap_cnt/8) − 1.
- LOAD: spec_head = 0, spec_tail = snap_cnt mod 48 (48 gives 0), spec_cnt = snap_cnt. spec_ptr_load_o and rec_done_o are high this cycle. LOAD → IDLE.
- rename_stall_o = state ≠ IDLE. retire_hold_o = state ∈ {SNAP, COPY, LOAD}.
- recover_req_i seen in SNAP, COPY or LOAD restarts at SNAP with a fresh snapshot. LOAD is suppressed in that case: no load pulse and no done pulse for the aborted run.
- arch_fl_cnt_i > 48 is clamped to 48.
- Write enables are 0 outside COPY. Index and data buses are don't-care when their we is 0. Implementation drives them to 0.

## Timing
- Request sampled at edge 0 → SNAP in cycle 1, COPY in cycles 2..1+B with B = ceil(cnt/8), LOAD in cycle 2+B, IDLE in cycle 3+B.
- cnt = 48: B = 6, LOAD in cycle 8. cnt = 0: LOAD in cycle 2.
- All outputs are decoded from registered state. The write path is combinational through arch_rd_data_i only.
- Reset: state = IDLE. All outputs are 0, including rec_err_o. Stall and hold drop asynchronously.
- Reset mid-COPY abandons the copy. Spec pointers are not loaded, so rename must also be flushed by reset.

## Configuration
- RFL_REC_CHECK_EN defined:
  - A 2^PREG_W-bit seen vector is cleared in SNAP.
  - In COPY, any active lane whose tag is already seen, or duplicated in the same beat, sets rec_err_o.
  - rec_err_o stays set until reset.
- Undefined: rec_err_o is tied 0 and no checker logic exists.

## Structure
- rename_pkg holds:
  - NUM_FL, PREG_W, IDX_W, LANES
  - the FSM state enum
  - a wrap-increment function (mod NUM_FL)
- Sub-module rfl_dup_chk, instantiated only under RFL_REC_CHECK_EN. It contains the seen vector and the intra-beat compare.

## Test plan
- cnt = 48, head = 0 → 6 COPY beats writing spec[0..47] = arch[0..47]; load head = 0, tail = 0, cnt = 48; done in cycle 8.
- cnt = 13, head = 44 → beat 0 reads arch 44..47, 0..3. Beat 1 reads arch 4..8, with lanes 5–7 we = 0. Load tail = 13, cnt = 13.
- cnt = 0 → no writes; load in cycle 2 with head = tail = cnt = 0.
- Second recover_req_i during beat 2 of a 48-entry run → returns to SNAP; exactly one done pulse, taken from the second snapshot.
- Reset asserted in COPY → all outputs 0 immediately; state IDLE after reset is released.
- RFL_REC_CHECK_EN defined, arch data holds tag 0x15 twice → rec_err_o = 1 by the end of COPY and held until reset. With the macro undefined → rec_err_o stays 0.
